keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 matrix keypad on the board's Pmod header. Drives the four
//   columns with a rotating active-low one-hot pattern and reads the four
//   active-low, pulled-up rows. Debounces a press and reports one 4-bit key
//   code per press. This is the input-side counterpart of the display anode
//   scanner and sits beside it in the top level.
// PARAMETERS
//   SCAN_DIV       1000   clk cycles per scan tick; column settle time
//   DEBOUNCE_TICKS 4      consecutive matching ticks to accept a press or release
//   REPEAT_TICKS   250    held ticks between auto-repeat pulses (KEYPAD_REPEAT_EN only)
// PORTS
//   clk        in   1  system clock; the only clock
//   reset      in   1  synchronous, active-high
//   row        in   4  keypad rows, async, active-low
//   col        out  4  keypad columns, active-low one-hot
//   key_code   out  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key
//   key_valid  out  1  one-cycle pulse when key_code is updated
//   key_held   out  1  high from acceptance until the release is debounced
// BEHAVIOUR
//   Reset values:
//     col=4'b1110 (col 0 driven), key_code=0, key_valid=0, key_held=0.
//     State SCAN, all counters 0, row synchroniser flops 4'b1111.
//     Reset wins over every other event. Asserting reset mid-press aborts it:
//     no key_valid is issued and scanning restarts at col 0.
//   Row sync: 2-flop synchroniser. All decisions use the synchronised row (rs).
//   Tick: divider counts 0..SCAN_DIV-1 and asserts tick for one cycle at
//     SCAN_DIV-1, then wraps to 0. rs is sampled only on tick.
//   Column ring: advances on tick in SCAN only, 1110->1101->1011->0111->1110.
//     col_idx 0..3 corresponds to the low bit position.
//   FSM, evaluated only on a tick:
//     SCAN:     rs==4'hF -> advance column.
//               Otherwise latch row_idx = lowest-index low bit, freeze column,
//               deb=1, go to DEBOUNCE.
//     DEBOUNCE: latched row low -> deb++. When deb reaches DEBOUNCE_TICKS:
//               load key_code, pulse key_valid the next cycle, go to HELD.
//               Latched row high -> go to SCAN and advance column (press rejected).
//     HELD:     key_held=1. rs==4'hF -> deb=1, go to RELEASE.
//     RELEASE:  rs==4'hF -> deb++. When deb reaches DEBOUNCE_TICKS: key_held=0,
//               go to SCAN and advance column.
//               Latched row low again -> go back to HELD (bounce; no new key_valid).
//   Only the latched row is tested in DEBOUNCE, HELD and RELEASE. Other rows
//     are ignored, and keys in other columns are invisible while the column is frozen.
//   DEBOUNCE_TICKS=1 accepts on the detection tick itself.
//   key_code holds its value until the next acceptance.
//   Latency: key_valid rises 1 cycle after the accepting tick.
// CONFIGURATION
//   KEYPAD_REPEAT_EN defined:
//     A repeat counter counts ticks in HELD. Every REPEAT_TICKS ticks it
//     re-pulses key_valid (key_code unchanged) and clears.
//     Cleared on entry to HELD, including the re-entry from RELEASE.
//   KEYPAD_REPEAT_EN undefined:
//     No repeat logic. REPEAT_TICKS is ignored. Exactly one key_valid per press.
// STRUCTURE
//   keypad_pkg holds:
//     state enum {SCAN, DEBOUNCE, HELD, RELEASE}
//     COL_RESET = 4'b1110
//     ROWS_IDLE = 4'hF
//     function first_low(row) -> 2-bit index
//   One sub-module, keypad_col_ring: 4-bit rotating ring with advance enable,
//   reset to COL_RESET, and col_idx output. The divider, synchroniser and FSM
//   stay in keypad_scanner.
// TESTING
//   Bench settings: SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5. The key model
//   pulls row r low while col[c]==0.
//   1. Idle rows (4'hF) for 40 cycles:
//      col cycles 1110,1101,1011,0111 with 4 cycles per step; key_valid never pulses.
//   2. Hold key r=2,c=1:
//      exactly one key_valid with key_code=4'b1001; key_held=1 until release,
//      then falls after 3 idle ticks.
//   3. Press r=0,c=3 for 2 ticks, then release:
//      no key_valid, key_held stays 0, scanning resumes at col 0.
//   4. Bounce at release (high 1 tick, low 1 tick, then high):
//      key_held stays 1 until 3 consecutive high ticks; still one key_valid only.
//   5. Assert reset during DEBOUNCE:
//      next cycle col=1110, outputs 0; no key_valid issued.
//   6. KEYPAD_REPEAT_EN, key r=3,c=3 held for 20 ticks:
//      initial key_valid (code 4'hF), then a re-pulse every 5 ticks.
//      Without the macro: exactly one pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'hF;

    // Index of the lowest active-low row; rows with a lower index win ties.
    function automatic logic [1:0] first_low(input logic [3:0] row);
        logic [1:0] idx;
        if (!row[0]) begin
            idx = 2'd0;
        end else if (!row[1]) begin
            idx = 2'd1;
        end else if (!row[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pad signals plus the decoded key report, grouped for the scanner port.
interface keypad_if;
    import keypad_pkg::*;

    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_col_ring.sv
// Active-low one-hot column driver that rotates one position per advance.
module keypad_col_ring
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [3:0] col,
    output logic [1:0] col_idx
);

    logic [3:0] ring_r;
    logic [1:0] idx_r;

    // Rotate the driven column; the index tracks the position of the low bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_r <= COL_RESET;
            idx_r  <= 2'd0;
        end else if (advance) begin
            ring_r <= {ring_r[2:0], ring_r[3]};
            idx_r  <= idx_r + 2'd1;
        end else begin
            ring_r <= ring_r;
            idx_r  <= idx_r;
        end
    end

    assign col     = ring_r;
    assign col_idx = idx_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchroniser, scan-tick divider, debounce FSM.
// Optional auto-repeat of key_valid while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 250
) (
    input logic       clk,
    input logic       reset,
    keypad_if.master  kif
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_TICKS);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_s;

    state_t           state_r, state_s;
    logic [DEB_W-1:0] deb_r, deb_s, deb_inc_s;
    logic [1:0]       row_idx_r, row_idx_s;
    logic [3:0]       key_code_r, key_code_s;
    logic             key_valid_r, key_valid_s;
    logic             key_held_r, key_held_s;
    logic             accept_s;
    logic             advance_s;
    logic             row_low_s;
    logic [1:0]       col_idx_s;
    logic [3:0]       col_s;

    keypad_col_ring u_col_ring (
        .clk     (clk),
        .reset   (reset),
        .advance (advance_s),
        .col     (col_s),
        .col_idx (col_idx_s)
    );

    // Two-flop synchroniser for the asynchronous rows; idle (all high) out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_r <= ROWS_IDLE;
            row_sync_r <= ROWS_IDLE;
        end else begin
            row_meta_r <= kif.row;
            row_sync_r <= row_meta_r;
        end
    end

    // Scan-tick divider: one tick per SCAN_DIV cycles, giving columns time to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    assign tick_s    = (div_cnt_r == DIV_LAST);
    assign deb_inc_s = deb_r + DEB_ONE;
    assign row_low_s = ~row_sync_r[row_idx_r];

    // Next-state logic; only the latched row matters once a column is frozen.
    always_comb begin
        state_s    = state_r;
        deb_s      = deb_r;
        row_idx_s  = row_idx_r;
        key_code_s = key_code_r;
        key_held_s = key_held_r;
        accept_s   = 1'b0;
        advance_s  = 1'b0;
        if (tick_s) begin
            case (state_r)
                SCAN: begin
                    if (row_sync_r == ROWS_IDLE) begin
                        advance_s = 1'b1;
                    end else begin
                        row_idx_s = first_low(row_sync_r);
                        deb_s     = DEB_ONE;
                        if (DEB_ONE == DEB_DONE) begin
                            key_code_s = {row_idx_s, col_idx_s};
                            accept_s   = 1'b1;
                            key_held_s = 1'b1;
                            state_s    = HELD;
                        end else begin
                            state_s = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (row_low_s) begin
                        deb_s = deb_inc_s;
                        if (deb_inc_s == DEB_DONE) begin
                            key_code_s = {row_idx_r, col_idx_s};
                            accept_s   = 1'b1;
                            key_held_s = 1'b1;
                            state_s    = HELD;
                        end else begin
                            state_s = DEBOUNCE;
                        end
                    end else begin
                        state_s   = SCAN;
                        advance_s = 1'b1;
                    end
                end
                HELD: begin
                    if (!row_low_s) begin
                        deb_s = DEB_ONE;
                        if (DEB_ONE == DEB_DONE) begin
                            key_held_s = 1'b0;
                            advance_s  = 1'b1;
                            state_s    = SCAN;
                        end else begin
                            state_s = RELEASE;
                        end
                    end else begin
                        state_s = HELD;
                    end
                end
                RELEASE: begin
                    if (!row_low_s) begin
                        deb_s = deb_inc_s;
                        if (deb_inc_s == DEB_DONE) begin
                            key_held_s = 1'b0;
                            advance_s  = 1'b1;
                            state_s    = SCAN;
                        end else begin
                            state_s = RELEASE;
                        end
                    end else begin
                        // Release bounce: resume holding without reporting a new key.
                        state_s = HELD;
                    end
                end
                default: begin
                    state_s    = SCAN;
                    key_held_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_TICKS);

    logic [REP_W-1:0] rep_cnt_r, rep_cnt_s, rep_inc_s;
    logic             held_entry_s;
    logic             held_tick_s;
    logic             repeat_pulse_s;

    assign held_entry_s = (state_s == HELD) && (state_r != HELD);
    assign held_tick_s  = tick_s && (state_r == HELD) && (state_s == HELD);
    assign rep_inc_s    = rep_cnt_r + REP_W'(1);

    // Repeat counter restarts on every entry to HELD, including a release bounce.
    always_comb begin
        rep_cnt_s      = rep_cnt_r;
        repeat_pulse_s = 1'b0;
        if (held_entry_s) begin
            rep_cnt_s = '0;
        end else if (held_tick_s) begin
            if (rep_inc_s == REP_DONE) begin
                rep_cnt_s      = '0;
                repeat_pulse_s = 1'b1;
            end else begin
                rep_cnt_s = rep_inc_s;
            end
        end else begin
            rep_cnt_s = rep_cnt_r;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_r <= '0;
        end else begin
            rep_cnt_r <= rep_cnt_s;
        end
    end

    assign key_valid_s = accept_s | repeat_pulse_s;
`else
    assign key_valid_s = accept_s;
`endif

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= SCAN;
            deb_r       <= '0;
            row_idx_r   <= 2'd0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            deb_r       <= deb_s;
            row_idx_r   <= row_idx_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

    assign kif.col       = col_s;
    assign kif.key_code  = key_code_r;
    assign kif.key_valid = key_valid_r;
    assign kif.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a key model driven from the column outputs.
`timescale 1ns/1ps
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SD = 4;
    localparam int DT = 3;
    localparam int RT = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pressed = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    int         n = 0;
    int         errors = 0;
    int         checks = 0;
    int         pulse_n[$];
    logic [3:0] pulse_code[$];

    keypad_if kif();

    assign kif.row = (pressed && kif.col[key_c] == 1'b0) ? ~(4'b0001 << key_r) : 4'hF;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT), .REPEAT_TICKS(RT)) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    // n = number of clock edges seen since reset was released
    always @(posedge clk) n <= reset ? 0 : n + 1;

    always @(negedge clk) begin
        if (!reset && kif.key_valid) begin
            pulse_n.push_back(n);
            pulse_code.push_back(kif.key_code);
        end
    end

    function automatic logic [3:0] col_of(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (idx % 4));
    endfunction

    task automatic apply_reset(input logic hold_key);
        @(negedge clk);
        reset = 1'b1;
        pressed = hold_key;
        repeat (3) @(negedge clk);
        pulse_n.delete();
        pulse_code.delete();
        reset = 1'b0;
    endtask

    task automatic wait_n(input int target);
        for (int k = 0; k < 4000 && n < target; k++) @(negedge clk);
        if (n != target) begin
            checks++;
            errors++;
            $display("FAIL wait_n: reached n=%0d, required n=%0d", n, target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({kif.col, kif.key_code, kif.key_valid, kif.key_held} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: col=%b code=%h valid=%b held=%b, required 1110/0/0/0",
                     kif.col, kif.key_code, kif.key_valid, kif.key_held);
        end
    endtask

    task automatic test_idle();
        logic [3:0] exp_col;
        apply_reset(1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            exp_col = col_of(n / SD);
            checks++;
            if ({kif.col, kif.key_valid, kif.key_held} !== {exp_col, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL idle_scan n=%0d: col=%b valid=%b held=%b, required col=%b valid=0 held=0",
                         n, kif.col, kif.key_valid, kif.key_held, exp_col);
            end
        end
    endtask

    // Key held from reset: detected on the first tick its column is driven, accepted DT-1 ticks later.
    task automatic run_press(input int r, input int c, input int hold, input string name);
        int n_a, n_r, exp_cnt;
        logic [3:0] code;
        key_r = 2'(r);
        key_c = 2'(c);
        code = 4'(r * 4 + c);
        apply_reset(1'b1);
        n_a = SD * (c + DT);
        n_r = n_a + SD * hold;
        wait_n(n_a - 1);
        checks++;
        if (kif.key_held !== 1'b0) begin
            errors++;
            $display("FAIL %s held_before_accept: got %b, required 0", name, kif.key_held);
        end
        wait_n(n_a);
        checks++;
        if (kif.key_held !== 1'b1) begin
            errors++;
            $display("FAIL %s held_at_accept: got %b, required 1", name, kif.key_held);
        end
        wait_n(n_r);
        pressed = 1'b0;
        wait_n(n_r + SD * DT - 1);
        checks++;
        if (kif.key_held !== 1'b1) begin
            errors++;
            $display("FAIL %s held_before_release: got %b, required 1", name, kif.key_held);
        end
        wait_n(n_r + SD * DT);
        checks++;
        if ({kif.key_held, kif.col} !== {1'b0, col_of(c + 1)}) begin
            errors++;
            $display("FAIL %s release: held=%b col=%b, required held=0 col=%b",
                     name, kif.key_held, kif.col, col_of(c + 1));
        end
        exp_cnt = 1;
`ifdef KEYPAD_REPEAT_EN
        exp_cnt = 1 + hold / RT;
`endif
        checks++;
        if (pulse_n.size() != exp_cnt) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d, required %0d", name, pulse_n.size(), exp_cnt);
        end
        for (int i = 0; i < exp_cnt && i < pulse_n.size(); i++) begin
            checks++;
            if (pulse_n[i] != n_a + i * SD * RT || pulse_code[i] !== code) begin
                errors++;
                $display("FAIL %s pulse%0d: at n=%0d code=%h, required n=%0d code=%h",
                         name, i, pulse_n[i], pulse_code[i], n_a + i * SD * RT, code);
            end
        end
    endtask

    task automatic test_short_press();
        logic held_seen;
        key_r = 2'd0;
        key_c = 2'd3;
        apply_reset(1'b1);
        wait_n(20);
        pressed = 1'b0;
        wait_n(23);
        checks++;
        if (kif.col !== 4'b0111) begin
            errors++;
            $display("FAIL short_frozen_col: got %b, required 0111", kif.col);
        end
        wait_n(24);
        checks++;
        if (kif.col !== 4'b1110) begin
            errors++;
            $display("FAIL short_resume_col: got %b, required 1110", kif.col);
        end
        held_seen = 1'b0;
        for (int k = 0; k < 4000 && n < 40; k++) begin
            @(negedge clk);
            held_seen = held_seen | kif.key_held;
        end
        checks++;
        if ({held_seen, 32'(pulse_n.size())} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL short_no_key: held_seen=%b pulses=%0d, required 0 and 0",
                     held_seen, pulse_n.size());
        end
    endtask

    task automatic test_bounce();
        logic held_dropped;
        key_r = 2'd1;
        key_c = 2'd2;
        apply_reset(1'b1);
        wait_n(32);
        pressed = 1'b0;
        wait_n(36);
        pressed = 1'b1;
        wait_n(40);
        pressed = 1'b0;
        held_dropped = 1'b0;
        for (int k = 0; k < 4000 && n < 51; k++) begin
            @(negedge clk);
            held_dropped = held_dropped | ~kif.key_held;
        end
        checks++;
        if (held_dropped !== 1'b0) begin
            errors++;
            $display("FAIL bounce_held: key_held dropped early, required 1 through n=51");
        end
        wait_n(52);
        checks++;
        if (kif.key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release: got %b, required 0", kif.key_held);
        end
        checks++;
        if (pulse_n.size() != 1 || pulse_n[0] != 20 || pulse_code[0] !== 4'h6) begin
            errors++;
            $display("FAIL bounce_pulses: count=%0d first_n=%0d, required 1 pulse at n=20 code 6",
                     pulse_n.size(), (pulse_n.size() > 0) ? pulse_n[0] : -1);
        end
    endtask

    task automatic test_reset_mid_press();
        key_r = 2'd2;
        key_c = 2'd1;
        apply_reset(1'b1);
        wait_n(10);
        reset = 1'b1;
        pressed = 1'b0;
        @(negedge clk);
        checks++;
        if ({kif.col, kif.key_code, kif.key_valid, kif.key_held} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: col=%b code=%h valid=%b held=%b, required 1110/0/0/0",
                     kif.col, kif.key_code, kif.key_valid, kif.key_held);
        end
        @(negedge clk);
        pulse_n.delete();
        pulse_code.delete();
        reset = 1'b0;
        wait_n(30);
        checks++;
        if (pulse_n.size() != 0 || kif.col !== col_of(30 / SD)) begin
            errors++;
            $display("FAIL reset_mid_resume: pulses=%0d col=%b, required 0 pulses col=%b",
                     pulse_n.size(), kif.col, col_of(30 / SD));
        end
    endtask

    task automatic test_random_presses();
        int r, c, hold;
        for (int i = 0; i < 6; i++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 16));
            run_press(r, c, hold, "random_press");
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        run_press(2, 1, 6, "hold_r2c1");
        test_short_press();
        test_bounce();
        test_reset_mid_press();
        run_press(3, 3, 20, "hold_r3c3");
        test_random_presses();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
